// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline definitions: EXE operand-select encodings and the
// per-stage shadow slot record used by the forwarding/hazard logic.
package forwarding_unit_pkg;

  // Widest register index a slot can carry; narrower indices are zero-extended.
  localparam int unsigned MAX_REG_ADDR_W = 8;

  // Shadow slot positions, oldest last.
  localparam int unsigned SLOT_EXE  = 0;
  localparam int unsigned SLOT_MEM  = 1;
  localparam int unsigned SLOT_WB   = 2;
  localparam int unsigned NUM_SLOTS = 3;

  // EXE operand source selects.
  typedef enum logic [1:0] {
    SEL_ID  = 2'd0,
    SEL_MEM = 2'd1,
    SEL_WB  = 2'd2
  } sel_e;

  typedef struct packed {
    logic                      valid;
    logic [MAX_REG_ADDR_W-1:0] dest;
    logic                      wb_en;
    logic                      mem_read;
  } slot_t;

endpackage

// File: rtl/forwarding_unit_fwd_match.sv
// Compares one ID source register against the EXE and MEM shadow slots and
// returns the forwarding select plus this source's hazard contribution.
module fwd_match
  import forwarding_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                      fwd_en,
  input  logic [REG_ADDR_W-1:0]     src,
  input  logic                      used,
  input  slot_t                     exe_slot,
  input  logic                      mem_valid,
  input  logic                      mem_wb_en,
  input  logic [MAX_REG_ADDR_W-1:0] mem_dest,
  output sel_e                      sel,
  output logic                      stall
);

  logic [MAX_REG_ADDR_W-1:0] src_ext;
  logic                      exe_hit;
  logic                      mem_hit;

  assign src_ext = MAX_REG_ADDR_W'(src);

  // Producer detection (r0 never matches), select priority and stall need.
  always_comb begin
    exe_hit = exe_slot.valid && exe_slot.wb_en && (exe_slot.dest == src_ext) && (src_ext != '0);
    mem_hit = mem_valid && mem_wb_en && (mem_dest == src_ext) && (src_ext != '0);
    sel     = SEL_ID;
    stall   = 1'b0;
    if (fwd_en) begin
      if (exe_hit)      sel = SEL_MEM;
      else if (mem_hit) sel = SEL_WB;
      stall = used && exe_hit && exe_slot.mem_read;
    end else begin
      stall = used && (exe_hit || mem_hit);
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Data-hazard unit: tracks EXE/MEM/WB destination shadows, registers EXE
// operand selects, raises load-use (or no-forwarding) stalls and counts them.
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_en,
  input  logic                  freeze,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src2,
  input  logic                  id_is_store,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  output logic [1:0]            val1_s,
  output logic [1:0]            val2_s,
  output logic [1:0]            ST_value_s,
  output logic                  hazard_stall,
  output logic [CNT_W-1:0]      stall_count
);

  slot_t            slots [NUM_SLOTS];
  slot_t            id_slot;
  sel_e             val1_q, val2_q, st_q;
  sel_e             sel1, sel2;
  logic             stall1, stall2;
  logic [CNT_W-1:0] cnt_q;

  assign id_slot = '{valid: id_valid, dest: MAX_REG_ADDR_W'(id_dest),
                     wb_en: id_wb_en, mem_read: id_mem_read};

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src1 (
    .fwd_en    (fwd_en),
    .src       (id_src1),
    .used      (1'b1),
    .exe_slot  (slots[SLOT_EXE]),
    .mem_valid (slots[SLOT_MEM].valid),
    .mem_wb_en (slots[SLOT_MEM].wb_en),
    .mem_dest  (slots[SLOT_MEM].dest),
    .sel       (sel1),
    .stall     (stall1)
  );

  fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_src2 (
    .fwd_en    (fwd_en),
    .src       (id_src2),
    .used      (id_use_src2 | id_is_store),
    .exe_slot  (slots[SLOT_EXE]),
    .mem_valid (slots[SLOT_MEM].valid),
    .mem_wb_en (slots[SLOT_MEM].wb_en),
    .mem_dest  (slots[SLOT_MEM].dest),
    .sel       (sel2),
    .stall     (stall2)
  );

  // Stall request only for a real ID instruction; still driven under freeze.
  always_comb begin
    hazard_stall = id_valid && (stall1 || stall2);
  end

  // Advance shadows and load selects with the instruction entering EXE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      val1_q <= SEL_ID;
      val2_q <= SEL_ID;
      st_q   <= SEL_ID;
    end else if (!freeze) begin
      slots[SLOT_WB]  <= slots[SLOT_MEM];
      slots[SLOT_MEM] <= slots[SLOT_EXE];
      if (hazard_stall) begin
        slots[SLOT_EXE] <= '0;
        val1_q          <= SEL_ID;
        val2_q          <= SEL_ID;
        st_q            <= SEL_ID;
      end else begin
        slots[SLOT_EXE] <= id_slot;
        val1_q          <= id_valid ? sel1 : SEL_ID;
        val2_q          <= (id_valid && id_use_src2) ? sel2 : SEL_ID;
        st_q            <= (id_valid && id_is_store) ? sel2 : SEL_ID;
      end
    end
  end

  // Saturating count of stall cycles that actually took effect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!freeze && hazard_stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign val1_s      = val1_q;
  assign val2_s      = val2_q;
  assign ST_value_s  = st_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: the driver applies one ID vector per
// cycle and queues the expected outputs; the monitor compares on negedge.
module tb_forwarding_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;
  localparam logic [2:0] ALL  = 3'b111;
  localparam logic [2:0] NONE = 3'b000;

  typedef struct {
    logic          v;
    logic [AW-1:0] s1, s2, d;
    logic          u2, st, wb, mr, fe, fz, rp;
  } in_t;

  typedef struct {
    string         name;
    logic [2:0]    mask;
    logic [1:0]    v1, v2, sv;
    logic          hz;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk, rst, fwd_en, freeze, id_valid, id_use_src2, id_is_store;
  logic          id_wb_en, id_mem_read, hazard_stall;
  logic [AW-1:0] id_src1, id_src2, id_dest;
  logic [1:0]    val1_s, val2_s, ST_value_s;
  logic [CW-1:0] stall_count;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  forwarding_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .fwd_en       (fwd_en),
    .freeze       (freeze),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src2  (id_use_src2),
    .id_is_store  (id_is_store),
    .id_dest      (id_dest),
    .id_wb_en     (id_wb_en),
    .id_mem_read  (id_mem_read),
    .val1_s       (val1_s),
    .val2_s       (val2_s),
    .ST_value_s   (ST_value_s),
    .hazard_stall (hazard_stall),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(logic v, logic [AW-1:0] d, logic [AW-1:0] s1, logic [AW-1:0] s2,
                             logic u2, logic st, logic wb, logic mr);
    in_t r;
    r.v = v; r.d = d; r.s1 = s1; r.s2 = s2; r.u2 = u2; r.st = st; r.wb = wb; r.mr = mr;
    r.fe = 1'b1; r.fz = 1'b0; r.rp = 1'b0;
    return r;
  endfunction

  function automatic in_t alu(logic [AW-1:0] d, logic [AW-1:0] s1, logic [AW-1:0] s2);
    return mk(1'b1, d, s1, s2, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic in_t lw(logic [AW-1:0] d, logic [AW-1:0] s1);
    return mk(1'b1, d, s1, '0, 1'b0, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic in_t sw(logic [AW-1:0] s1, logic [AW-1:0] s2);
    return mk(1'b1, '0, s1, s2, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic in_t nop();
    return mk(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic apply(input in_t i);
    id_valid = i.v; id_src1 = i.s1; id_src2 = i.s2; id_dest = i.d;
    id_use_src2 = i.u2; id_is_store = i.st; id_wb_en = i.wb; id_mem_read = i.mr;
    fwd_en = i.fe; freeze = i.fz;
  endtask

  // One cycle: drive inputs just after the edge, optionally pulse reset
  // before the next edge, and queue what the negedge sample must show.
  task automatic cyc(input string nm, input in_t i, input logic [2:0] mask,
                     input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] es,
                     input logic eh, input logic [CW-1:0] ec);
    exp_t x;
    @(posedge clk);
    #1;
    apply(i);
    if (i.rp) begin
      #1 rst = 1'b0;
      #1 rst = 1'b1;
    end
    x.name = nm; x.mask = mask; x.v1 = e1; x.v2 = e2; x.sv = es; x.hz = eh; x.cnt = ec;
    sb.push_back(x);
  endtask

  task automatic check(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare the selected fields.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.mask[0]) begin
        check({e.name, ".val1_s"}, CW'(val1_s), CW'(e.v1));
        check({e.name, ".val2_s"}, CW'(val2_s), CW'(e.v2));
        check({e.name, ".ST_value_s"}, CW'(ST_value_s), CW'(e.sv));
      end
      if (e.mask[1]) check({e.name, ".hazard_stall"}, CW'(hazard_stall), CW'(e.hz));
      if (e.mask[2]) check({e.name, ".stall_count"}, stall_count, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t;
    rst = 1'b1;
    apply(nop());
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    cyc("reset_state",      alu(3, 1, 2), ALL, 0, 0, 0, 0, 0);
    cyc("alu_dep_issue",    alu(4, 3, 5), ALL, 0, 0, 0, 0, 0);
    cyc("exe_fwd_src1",     nop(),        ALL, 1, 0, 0, 0, 0);
    cyc("lw_issue",         lw(2, 1),     ALL, 0, 0, 0, 0, 0);
    cyc("load_use_stall",   alu(6, 2, 2), ALL, 0, 0, 0, 1, 0);
    cyc("after_stall",      alu(6, 2, 2), ALL, 0, 0, 0, 0, 1);
    cyc("wb_fwd_both",      nop(),        ALL, 2, 2, 0, 0, 1);
    cyc("r7_first",         alu(7, 1, 1), ALL, 0, 0, 0, 0, 1);
    cyc("r7_second",        alu(7, 1, 1), ALL, 0, 0, 0, 0, 1);
    cyc("store_issue",      sw(1, 7),     ALL, 0, 0, 0, 0, 1);
    t = alu(8, 1, 7); t.u2 = 1'b0;
    cyc("store_prio_mem",   t,            ALL, 0, 0, 1, 0, 1);
    cyc("src2_unused",      nop(),        ALL, 0, 0, 0, 0, 1);
    cyc("lw_r0_issue",      lw(0, 1),     ALL, 0, 0, 0, 0, 1);
    cyc("r0_no_stall",      alu(9, 0, 0), ALL, 0, 0, 0, 0, 1);
    cyc("r0_no_fwd",        alu(10, 1, 1), ALL, 0, 0, 0, 0, 1);
    cyc("nofwd_prep",       nop(),        ALL, 0, 0, 0, 0, 1);
    t = alu(11, 10, 1); t.fe = 1'b0;
    cyc("nofwd_mem_stall",  t,            ALL, 0, 0, 0, 1, 1);
    cyc("nofwd_release",    t,            ALL, 0, 0, 0, 0, 2);
    cyc("nofwd_sel_zero",   nop(),        ALL, 0, 0, 0, 0, 2);
    cyc("lw12_issue",       lw(12, 1),    ALL, 0, 0, 0, 0, 2);
    t = alu(13, 12, 1); t.fz = 1'b1;
    repeat (3) cyc("freeze_hold", t,      ALL, 0, 0, 0, 1, 2);
    t.fz = 1'b0;
    cyc("freeze_release",   t,            ALL, 0, 0, 0, 1, 2);
    cyc("post_freeze",      t,            ALL, 0, 0, 0, 0, 3);
    t = nop(); t.fz = 1'b1;
    cyc("freeze_sel_set",   t,            ALL, 2, 0, 0, 0, 3);
    cyc("freeze_sel_hold",  nop(),        ALL, 2, 0, 0, 0, 3);
    cyc("lw14_issue",       lw(14, 1),    ALL, 0, 0, 0, 0, 3);
    t = alu(15, 14, 14); t.rp = 1'b1;
    cyc("async_reset",      t,            ALL, 0, 0, 0, 0, 0);
    t = nop(); t.s1 = 15; t.s2 = 15; t.fe = 1'b0;
    cyc("invalid_no_stall", t,            ALL, 0, 0, 0, 0, 0);
    t = alu(20, 20, 1); t.fe = 1'b0;
    repeat (40) cyc("sat_run", t, NONE, 0, 0, 0, 0, 0);
    cyc("sat_hold",         nop(),        ALL, 0, 0, 0, 0, 4'hF);
    cyc("sat_hold2",        nop(),        ALL, 0, 0, 0, 0, 4'hF);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
